// File: rtl/riscv_retire_status.sv
// riscv_retire_status: producer side of the core's test-status interface.
// Builds NUM_INST, OUTPUT_PORT, HALT and TIMEOUT from per-instruction retire
// events issued by the multi-cycle control FSM. All outputs are registered.
//
// Optional feature macro: RETIRE_WATCHDOG_EN
//   defined   : idle-cycle watchdog forces HALTED and raises TIMEOUT after
//               WDT_LIMIT consecutive cycles without a retire.
//   undefined : no idle counter, TIMEOUT tied low.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// RUN     | normal operation, no halt prefix pending
// ARMED   | last accepted retire was HALT_PREFIX; HALT_INST next halts core
// HALTED  | terminal until reset; retires ignored, outputs frozen

module riscv_retire_status #(
    parameter logic [31:0] HALT_PREFIX = 32'h00c00093,
    parameter logic [31:0] HALT_INST   = 32'h00008067,
    parameter int unsigned WDT_LIMIT   = 1024
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        RETIRE,
    input  logic [31:0] INST,
    input  logic [1:0]  CLASS,
    input  logic [31:0] RF_WD,
    input  logic        BR_TAKEN,
    input  logic [11:0] ST_ADDR,
    output logic [31:0] NUM_INST,
    output logic [31:0] OUTPUT_PORT,
    output logic        HALT,
    output logic        TIMEOUT
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_ARMED  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] num_q, num_d;
    logic [31:0] out_q, out_d;
    logic        accept;
    logic        wdt_fire;

    assign accept = RETIRE && (state_q != ST_HALTED);

`ifdef RETIRE_WATCHDOG_EN
    localparam logic [31:0] WDT_LAST = 32'(WDT_LIMIT - 1);

    logic [31:0] idle_q, idle_d;
    logic        timeout_q, timeout_d;

    // Firing on the last idle cycle before the limit makes HALT/TIMEOUT
    // appear on the same edge the counter would reach WDT_LIMIT; a retire
    // on that edge takes priority and clears the counter instead.
    assign wdt_fire = !RETIRE && (state_q != ST_HALTED) && (idle_q == WDT_LAST);

    // Idle counter and sticky timeout next-state.
    always_comb begin
        idle_d    = idle_q;
        timeout_d = timeout_q;
        if (accept) begin
            idle_d = '0;
        end else if (state_q != ST_HALTED) begin
            idle_d = idle_q + 32'd1;
        end
        if (wdt_fire) begin
            timeout_d = 1'b1;
        end
    end

    // Watchdog registers.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            idle_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            idle_q    <= idle_d;
            timeout_q <= timeout_d;
        end
    end

    assign TIMEOUT = timeout_q;
`else
    assign wdt_fire = 1'b0;
    assign TIMEOUT  = 1'b0;
`endif

    // Halt FSM state register.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Halt FSM next-state: moves only on accepted retires or watchdog expiry.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (accept && (INST == HALT_PREFIX)) begin
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (accept) begin
                    if (INST == HALT_INST) begin
                        state_d = ST_HALTED;
                    end else if (INST == HALT_PREFIX) begin
                        state_d = ST_ARMED;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_RUN;
        endcase
        if (wdt_fire) begin
            state_d = ST_HALTED;
        end
    end

    // Halt FSM output: HALT decodes the registered state, so it is glitch-free.
    always_comb begin
        HALT = (state_q == ST_HALTED);
    end

    // Retire counter and result next-state; frozen once halted.
    always_comb begin
        num_d = num_q;
        out_d = out_q;
        if (accept) begin
            if (num_q != 32'hFFFF_FFFF) begin
                num_d = num_q + 32'd1;
            end
            case (CLASS)
                2'd0:    out_d = RF_WD;
                2'd1:    out_d = {31'b0, BR_TAKEN};
                2'd2:    out_d = {20'b0, ST_ADDR};
                default: out_d = out_q;
            endcase
        end
    end

    // Status registers driving the top-level ports.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            num_q <= '0;
            out_q <= '0;
        end else begin
            num_q <= num_d;
            out_q <= out_d;
        end
    end

    assign NUM_INST    = num_q;
    assign OUTPUT_PORT = out_q;

endmodule

// File: tb/tb_riscv_retire_status.sv
// Directed testbench for riscv_retire_status; watchdog steps are included
// when RETIRE_WATCHDOG_EN is defined (limit shortened to 8 cycles).
module tb_riscv_retire_status;

    localparam logic [31:0] PREFIX = 32'h00c00093;
    localparam logic [31:0] HINST  = 32'h00008067;
    localparam logic [31:0] NOP    = 32'h00000013;
`ifdef RETIRE_WATCHDOG_EN
    localparam int unsigned TB_WDT = 8;
`else
    localparam int unsigned TB_WDT = 1024;
`endif

    logic        CLK = 1'b0;
    logic        RSTn;
    logic        RETIRE;
    logic [31:0] INST;
    logic [1:0]  CLASS;
    logic [31:0] RF_WD;
    logic        BR_TAKEN;
    logic [11:0] ST_ADDR;
    logic [31:0] NUM_INST;
    logic [31:0] OUTPUT_PORT;
    logic        HALT;
    logic        TIMEOUT;

    int tests = 0;
    int fails = 0;

    riscv_retire_status #(
        .HALT_PREFIX (PREFIX),
        .HALT_INST   (HINST),
        .WDT_LIMIT   (TB_WDT)
    ) dut (
        .CLK         (CLK),
        .RSTn        (RSTn),
        .RETIRE      (RETIRE),
        .INST        (INST),
        .CLASS       (CLASS),
        .RF_WD       (RF_WD),
        .BR_TAKEN    (BR_TAKEN),
        .ST_ADDR     (ST_ADDR),
        .NUM_INST    (NUM_INST),
        .OUTPUT_PORT (OUTPUT_PORT),
        .HALT        (HALT),
        .TIMEOUT     (TIMEOUT)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic retire(input logic [31:0] inst, input logic [1:0] cls,
                          input logic [31:0] wd, input logic br, input logic [11:0] st);
        RETIRE   = 1'b1;
        INST     = inst;
        CLASS    = cls;
        RF_WD    = wd;
        BR_TAKEN = br;
        ST_ADDR  = st;
        step();
        RETIRE   = 1'b0;
        INST     = 32'hDEAD_BEEF;
        RF_WD    = 32'hBAD0_BAD0;
    endtask

    task automatic idle(input int n);
        RETIRE = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        RSTn   = 1'b0;
        RETIRE = 1'b1;
        step();
        RSTn   = 1'b1;
        RETIRE = 1'b0;
    endtask

    initial begin
        RSTn = 1'b0; RETIRE = 1'b0; INST = NOP; CLASS = 2'd0;
        RF_WD = 32'h1234; BR_TAKEN = 1'b1; ST_ADDR = 12'hABC;

        // Reset held 3 cycles while RETIRE pulses: reset wins.
        for (int i = 0; i < 3; i++) begin
            RETIRE = ~RETIRE;
            step();
            check("rst_num", NUM_INST, 32'd0);
            check("rst_out", OUTPUT_PORT, 32'd0);
            check("rst_halt", {31'b0, HALT}, 32'd0);
        end
        check("rst_timeout", {31'b0, TIMEOUT}, 32'd0);
        RSTn = 1'b1; RETIRE = 1'b0;
        step();
        check("idle_num", NUM_INST, 32'd0);

        // Class-dependent result update.
        retire(NOP, 2'd0, 32'd5, 1'b0, 12'h000);
        check("cls0_num", NUM_INST, 32'd1);
        check("cls0_out", OUTPUT_PORT, 32'd5);
        retire(NOP, 2'd1, 32'd77, 1'b1, 12'h000);
        check("cls1_num", NUM_INST, 32'd2);
        check("cls1_out", OUTPUT_PORT, 32'd1);
        retire(NOP, 2'd2, 32'd77, 1'b0, 12'h014);
        check("cls2_num", NUM_INST, 32'd3);
        check("cls2_out", OUTPUT_PORT, 32'h14);
        retire(NOP, 2'd3, 32'd77, 1'b1, 12'hFFF);
        check("cls3_num", NUM_INST, 32'd4);
        check("cls3_out", OUTPUT_PORT, 32'h14);
        retire(NOP, 2'd1, 32'd77, 1'b0, 12'h000);
        check("cls1_nt_out", OUTPUT_PORT, 32'd0);

        // Halt sequence with idle cycles between prefix and halt instruction.
        do_reset();
        retire(PREFIX, 2'd0, 32'd12, 1'b0, 12'h000);
        check("pfx_num", NUM_INST, 32'd1);
        check("pfx_out", OUTPUT_PORT, 32'd12);
        check("pfx_halt", {31'b0, HALT}, 32'd0);
        idle(2);
        check("armed_idle_halt", {31'b0, HALT}, 32'd0);
        retire(HINST, 2'd3, 32'd0, 1'b0, 12'h000);
        check("halt_flag", {31'b0, HALT}, 32'd1);
        check("halt_num", NUM_INST, 32'd2);
        check("halt_out", OUTPUT_PORT, 32'd12);
        for (int i = 0; i < 3; i++) retire(NOP, 2'd0, 32'd99, 1'b1, 12'h001);
        check("frozen_num", NUM_INST, 32'd2);
        check("frozen_out", OUTPUT_PORT, 32'd12);
        check("sticky_halt", {31'b0, HALT}, 32'd1);
        check("halt_no_timeout", {31'b0, TIMEOUT}, 32'd0);

        // Reset after halt, then resume counting.
        do_reset();
        check("rah_num", NUM_INST, 32'd0);
        check("rah_out", OUTPUT_PORT, 32'd0);
        check("rah_halt", {31'b0, HALT}, 32'd0);
        retire(NOP, 2'd0, 32'd7, 1'b0, 12'h000);
        check("rah_retire_num", NUM_INST, 32'd1);
        check("rah_retire_out", OUTPUT_PORT, 32'd7);

        // Broken prefix: intervening instruction disarms.
        do_reset();
        retire(PREFIX, 2'd0, 32'd12, 1'b0, 12'h000);
        retire(NOP, 2'd0, 32'd0, 1'b0, 12'h000);
        retire(HINST, 2'd3, 32'd0, 1'b0, 12'h000);
        check("broken_halt", {31'b0, HALT}, 32'd0);
        check("broken_num", NUM_INST, 32'd3);

        // Halt instruction without prefix, then repeated prefix stays armed.
        retire(HINST, 2'd3, 32'd0, 1'b0, 12'h000);
        check("bare_halt", {31'b0, HALT}, 32'd0);
        retire(PREFIX, 2'd0, 32'd12, 1'b0, 12'h000);
        retire(PREFIX, 2'd2, 32'd0, 1'b0, 12'h0A5);
        retire(HINST, 2'd0, 32'd55, 1'b0, 12'h000);
        check("rearm_halt", {31'b0, HALT}, 32'd1);
        check("rearm_num", NUM_INST, 32'd7);
        check("rearm_out", OUTPUT_PORT, 32'd55);

`ifdef RETIRE_WATCHDOG_EN
        // Watchdog expiry after 8 idle cycles.
        do_reset();
        retire(NOP, 2'd0, 32'd3, 1'b0, 12'h000);
        idle(7);
        check("wdt_pre_halt", {31'b0, HALT}, 32'd0);
        check("wdt_pre_to", {31'b0, TIMEOUT}, 32'd0);
        idle(1);
        check("wdt_halt", {31'b0, HALT}, 32'd1);
        check("wdt_timeout", {31'b0, TIMEOUT}, 32'd1);
        check("wdt_num", NUM_INST, 32'd1);
        retire(NOP, 2'd0, 32'd9, 1'b0, 12'h000);
        check("wdt_frozen", NUM_INST, 32'd1);
        check("wdt_sticky", {31'b0, TIMEOUT}, 32'd1);

        // Retire on the limit edge wins.
        do_reset();
        retire(NOP, 2'd0, 32'd3, 1'b0, 12'h000);
        idle(7);
        retire(NOP, 2'd0, 32'd4, 1'b0, 12'h000);
        check("wdt_race_to", {31'b0, TIMEOUT}, 32'd0);
        check("wdt_race_halt", {31'b0, HALT}, 32'd0);
        check("wdt_race_num", NUM_INST, 32'd2);
        idle(7);
        check("wdt_restart_to", {31'b0, TIMEOUT}, 32'd0);
        idle(1);
        check("wdt_restart_fire", {31'b0, TIMEOUT}, 32'd1);
`else
        // Without the watchdog, long idle stretches never halt the core.
        do_reset();
        retire(NOP, 2'd0, 32'd3, 1'b0, 12'h000);
        idle(1100);
        check("nowdt_halt", {31'b0, HALT}, 32'd0);
        check("nowdt_timeout", {31'b0, TIMEOUT}, 32'd0);
        check("nowdt_num", NUM_INST, 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
